// File: rtl/tdm_pkg.sv
// Shared definitions for the 1:4 TDM deserializer: framing states and slot geometry.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

endpackage

// File: rtl/tdm_demux_1to4.sv
// Receive-side 1:4 TDM deserializer: tracks slot position against a frame marker and
// emits each complete four-slot frame as one registered parallel word.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [NUM_SLOTS*W-1:0] dout,
  output logic                 dout_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 sync_err
);

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(NUM_SLOTS - 1);

  state_e                          state_q, state_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [NUM_SLOTS-2:0][W-1:0]     hold_q, hold_d;
  logic [NUM_SLOTS*W-1:0]          dout_q, dout_d;
  logic                            dout_valid_q, dout_valid_d;
  logic                            sync_err_q, sync_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      slot_q       <= '0;
      hold_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_start) begin
            hold_d[0] = din;
            slot_d    = SLOT_W'(1);
            state_d   = StLocked;
          end
        end
        StLocked: begin
          if (frame_start) begin
            // An early marker abandons the partial frame and restarts at slot 0.
            sync_err_d = (slot_q != '0);
            hold_d[0]  = din;
            slot_d     = SLOT_W'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else if (slot_q == LastSlot) begin
            dout_d       = {din, hold_q};
            dout_valid_d = 1'b1;
            slot_d       = '0;
          end else begin
            hold_d[slot_q] = din;
            slot_d         = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == StLocked);
  assign sync_err   = sync_err_q;

endmodule
